// File: rtl/data_release_pkg.sv
// data_release shared types: FSM state encoding and index sizing helper.
package data_release_pkg;

    typedef enum logic [1:0] {
        ST_FILL    = 2'd0,
        ST_DISCARD = 2'd1,
        ST_PLAY    = 2'd2
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/data_release_if.sv
// AXI-Stream bundle feeding the playback buffer.
interface data_release_if #(
    parameter int W = 32
) ();

    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tlast;
    logic         tready;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );

endinterface

// File: rtl/data_release_sample_ram.sv
// Simple dual-port sample buffer: synchronous write, registered read.
module data_release_sample_ram #(
    parameter int DW    = 32,
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/data_release.sv
// Buffers one stream frame, then plays it to the DAC one sample per request edge.
module data_release
    import data_release_pkg::*;
#(
    parameter int DATA_WIDTH           = 32,
    parameter int TOTAL_SAMPLES        = 1024,
    parameter int C_S_AXIS_TDATA_WIDTH = 32
) (
    input  logic                  m_axis_aclk,
    input  logic                  m_axis_aresetn,
    data_release_if.slave         s_axis,
    input  logic                  dac_req,
    output logic [DATA_WIDTH-1:0] dac_data,
    output logic                  dac_valid,
    output logic                  frame_done,
    output logic                  frame_err,
    output logic                  underrun
);

    localparam int AW = idx_w(TOTAL_SAMPLES);
    localparam logic [AW-1:0] LAST_IDX = AW'(TOTAL_SAMPLES - 1);

    state_t          r_state;
    state_t          w_next_state;
    logic [AW-1:0]   r_wr_idx;
    logic [AW-1:0]   w_wr_idx_nxt;
    logic [AW-1:0]   r_rd_idx;
    logic [AW-1:0]   w_rd_idx_nxt;
    logic            r_req_d;
    logic            r_tready;
    logic            r_rd_pend;
    logic            r_last_pend;
    logic            w_req_edge;
    logic            w_beat;
    logic            w_we;
    logic            w_re;
    logic            w_err;
    logic            w_last_rd;
    logic            w_underrun;
    logic [DATA_WIDTH-1:0] w_rdata;

    if (C_S_AXIS_TDATA_WIDTH > DATA_WIDTH) begin : g_hi
        logic w_unused_hi;
        assign w_unused_hi =
            ^s_axis.tdata[C_S_AXIS_TDATA_WIDTH-1:DATA_WIDTH];
    end

    assign s_axis.tready = r_tready;
    assign w_req_edge    = dac_req & ~r_req_d;
    assign w_beat        = s_axis.tvalid & r_tready;

    data_release_sample_ram #(
        .DW    (DATA_WIDTH),
        .DEPTH (TOTAL_SAMPLES),
        .AW    (AW)
    ) u_sample_ram (
        .i_clk   (m_axis_aclk),
        .i_we    (w_we),
        .i_waddr (r_wr_idx),
        .i_wdata (s_axis.tdata[DATA_WIDTH-1:0]),
        .i_re    (w_re),
        .i_raddr (r_rd_idx),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_wr_idx_nxt = r_wr_idx;
        w_rd_idx_nxt = r_rd_idx;
        w_we         = 1'b0;
        w_re         = 1'b0;
        w_err        = 1'b0;
        w_last_rd    = 1'b0;
        unique case (r_state)
            ST_FILL: begin
                if (w_beat) begin
                    w_we = 1'b1;
                    if (s_axis.tlast) begin
                        w_wr_idx_nxt = '0;
                        if (r_wr_idx == LAST_IDX) begin
                            w_next_state = ST_PLAY;
                            w_rd_idx_nxt = '0;
                        end else begin
                            w_err = 1'b1;
                        end
                    end else if (r_wr_idx == LAST_IDX) begin
                        w_err        = 1'b1;
                        w_wr_idx_nxt = '0;
                        w_next_state = ST_DISCARD;
                    end else begin
                        w_wr_idx_nxt = r_wr_idx + 1'b1;
                    end
                end
            end
            ST_DISCARD: begin
                if (w_beat && s_axis.tlast) begin
                    w_next_state = ST_FILL;
                    w_wr_idx_nxt = '0;
                end
            end
            ST_PLAY: begin
                if (w_req_edge) begin
                    w_re = 1'b1;
                    if (r_rd_idx == LAST_IDX) begin
                        w_last_rd    = 1'b1;
                        w_next_state = ST_FILL;
                        w_wr_idx_nxt = '0;
                        w_rd_idx_nxt = '0;
                    end else begin
                        w_rd_idx_nxt = r_rd_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_next_state = ST_FILL;
                w_wr_idx_nxt = '0;
                w_rd_idx_nxt = '0;
            end
        endcase
        w_underrun = w_req_edge && (r_state != ST_PLAY);
    end

    // read data lands in the RAM register first, then in dac_data
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            r_wr_idx    <= '0;
            r_rd_idx    <= '0;
            r_req_d     <= 1'b0;
            r_tready    <= 1'b0;
            r_rd_pend   <= 1'b0;
            r_last_pend <= 1'b0;
            dac_data    <= '0;
            dac_valid   <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            r_wr_idx    <= w_wr_idx_nxt;
            r_rd_idx    <= w_rd_idx_nxt;
            r_req_d     <= dac_req;
            r_tready    <= (w_next_state != ST_PLAY);
            r_rd_pend   <= w_re;
            r_last_pend <= w_last_rd;
            dac_valid   <= r_rd_pend;
            frame_done  <= r_last_pend;
            frame_err   <= w_err;
            underrun    <= w_underrun;
            if (r_rd_pend) begin
                dac_data <= w_rdata;
            end
        end
    end

endmodule
